shake256_squeeze: RTL and testbench
===================================

SHAKE256_SQUEEZE -- requirements
Module: shake256_squeeze

Interface
REQ-001 Parameter RATE_LANES, default 17, SHAKE256 rate in 64-bit lanes (1088 bits).
REQ-002 Parameter LEN_W, default 16, width of the requested output length in words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a squeeze.
REQ-006 out_len  input  LEN_W  number of 64-bit output words requested; sampled with start.
REQ-007 state_valid  input  1  state_in holds a valid post-permutation Keccak state.
REQ-008 state_in  input  64 x [0:4][0:4]  Keccak state, indexed A[x][y], lane bit z = bit z.
REQ-009 perm_req  output  1  one-cycle pulse requesting one more Keccak-f[1600] permutation.
REQ-010 out_data  output  64  output word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 out_last  output  1  current word is the final requested word.
REQ-014 busy  output  1  squeeze in progress.
REQ-015 done  output  1  one-cycle pulse when a squeeze completes.

Function
REQ-016 FSM states: IDLE, WAIT_STATE, EMIT.
REQ-017 IDLE: start with out_len>0 latches remaining=out_len and moves to WAIT_STATE; start with out_len=0 pulses done next cycle and stays in IDLE.
REQ-018 WAIT_STATE: state_valid captures lanes i=0..RATE_LANES-1 (lane i = A[i%5][i/5]) into an internal buffer, sets lane_idx=0 and moves to EMIT; no output is produced in the capture cycle.
REQ-019 EMIT: out_valid=1 and out_data=buffer[lane_idx]; out_data and out_last stay stable while out_valid=1 and out_ready=0.
REQ-020 A transfer occurs when out_valid and out_ready are both 1; on each transfer remaining decrements and lane_idx increments.
REQ-021 out_last=1 exactly when in EMIT and remaining==1.
REQ-022 A transfer with remaining==1 returns to IDLE and pulses done in the following cycle; this takes priority over rate exhaustion.
REQ-023 A transfer with lane_idx==RATE_LANES-1 and remaining>1 pulses perm_req for one cycle and returns to WAIT_STATE.
REQ-024 The first block uses the caller-provided state (no perm_req); each further block requires exactly one perm_req.
REQ-025 busy=1 in WAIT_STATE and EMIT, 0 in IDLE.
REQ-026 start while busy is ignored; state_valid outside WAIT_STATE is ignored.
REQ-027 Maximum throughput: one word per cycle within a block; a block boundary costs perm_req plus the wait for state_valid plus one capture cycle.

Reset
REQ-028 rst forces IDLE, remaining=0, lane_idx=0, out_valid=0, out_last=0, out_data=0, perm_req=0, busy=0, done=0.
REQ-029 rst mid-squeeze abandons it without a done pulse; the buffer contents need not be cleared.

Structure
REQ-030 Shared package shake_pkg holds LANE_W=64, RATE_LANES=17, the state array typedef (64-bit [0:4][0:4]) and the FSM state enum.
REQ-031 No sub-module; the lane buffer is a RATE_LANES x 64 register array (or equivalent shift register) inside this module.

Verification
REQ-032 Let lane i = 64'hA5A5_0000_0000_0000 | i. start, out_len=3, state_valid one cycle, out_ready=1 -> words ...0000, ...0001, ...0002; out_last on the third; done one cycle later; no perm_req.
REQ-033 out_len=17 -> 17 words (lanes 0..16), out_last on lane 16, no perm_req.
REQ-034 out_len=20 -> 17 words, then one perm_req pulse; second state (lanes 64'h5A5A_..._i) -> words i=0..2, out_last on the 20th word, then done.
REQ-035 out_ready toggling 1,0,0,1 during EMIT -> out_data/out_last held while stalled; no word lost or duplicated.
REQ-036 start with out_len=0 -> done pulse only, busy stays 0; start while busy and state_valid in IDLE -> no effect.
REQ-037 rst asserted in EMIT after the second word -> all outputs 0 the next cycle, no done; a new start with out_len=1 then completes normally.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared constants, Keccak state type and squeeze FSM encoding for the SHAKE256 blocks.
package shake_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned RATE_LANES = 17;

  typedef logic [0:4][0:4][LANE_W-1:0] keccak_state_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STATE,
    EMIT
  } sq_state_e;

endpackage

// File: rtl/shake256_squeeze.sv
// SHAKE256 squeeze engine: streams rate lanes of successive Keccak states as 64-bit words,
// requesting one extra permutation per block beyond the first.
module shake256_squeeze #(
  parameter int unsigned RATE_LANES = shake_pkg::RATE_LANES,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [LEN_W-1:0]                      out_len,
  input  logic                                  state_valid,
  input  logic [0:4][0:4][shake_pkg::LANE_W-1:0] state_in,
  output logic                                  perm_req,
  output logic [shake_pkg::LANE_W-1:0]          out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done
);
  import shake_pkg::*;

  localparam int unsigned IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  sq_state_e            state_q, state_n;
  logic [LEN_W-1:0]     remaining_q, remaining_n;
  logic [IDX_W-1:0]     lane_idx_q, lane_idx_n;
  logic [LANE_W-1:0]    buffer [RATE_LANES];
  keccak_state_t        st;
  logic                 capture;
  logic                 perm_req_n, done_n, out_valid_n, out_last_n, busy_n;
  logic [LANE_W-1:0]    out_data_n;

  assign st = state_in;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_n     = state_q;
    remaining_n = remaining_q;
    lane_idx_n  = lane_idx_q;
    capture     = 1'b0;
    perm_req_n  = 1'b0;
    done_n      = 1'b0;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    out_data_n  = '0;
    busy_n      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (out_len == '0) begin
            done_n = 1'b1;
          end else begin
            remaining_n = out_len;
            state_n     = WAIT_STATE;
          end
        end
      end
      WAIT_STATE: begin
        if (state_valid) begin
          capture    = 1'b1;
          lane_idx_n = '0;
          state_n    = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          remaining_n = remaining_q - LEN_W'(1);
          // Final word wins over rate exhaustion so no spurious permutation is requested.
          if (remaining_q == LEN_W'(1)) begin
            state_n    = IDLE;
            done_n     = 1'b1;
            lane_idx_n = '0;
          end else if (lane_idx_q == LAST_IDX) begin
            state_n    = WAIT_STATE;
            perm_req_n = 1'b1;
            lane_idx_n = '0;
          end else begin
            lane_idx_n = lane_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n      = (state_n != IDLE);
    out_valid_n = (state_n == EMIT);
    out_last_n  = out_valid_n && (remaining_n == LEN_W'(1));
    // Lane 0 bypasses the buffer in the capture cycle since the buffer is written on the same edge.
    if (capture) begin
      out_data_n = st[0][0];
    end else if (out_valid_n) begin
      out_data_n = buffer[lane_idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      lane_idx_q  <= '0;
      perm_req    <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      remaining_q <= remaining_n;
      lane_idx_q  <= lane_idx_n;
      perm_req    <= perm_req_n;
      done        <= done_n;
      out_valid   <= out_valid_n;
      out_last    <= out_last_n;
      out_data    <= out_data_n;
      busy        <= busy_n;
    end
  end

  // Rate-lane capture: lane i lives at A[i%5][i/5].
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < RATE_LANES; i++) begin
        buffer[i] <= st[3'(i % 5)][3'(i / 5)];
      end
    end
  end

endmodule

// File: tb/tb_shake256_squeeze.sv
// Scoreboard bench for shake256_squeeze: lane-list reference model, random ready/state timing.
module tb_shake256_squeeze;
  import shake_pkg::*;

  localparam int unsigned RL = 17;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [15:0]          out_len;
  logic                 state_valid;
  keccak_state_t        state_in;
  logic                 perm_req;
  logic [63:0]          out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  shake256_squeeze #(.RATE_LANES(RL), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .out_len(out_len),
    .state_valid(state_valid), .state_in(state_in), .perm_req(perm_req),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  keccak_state_t blk_q[$];
  logic [63:0]   exp_data_q[$];
  bit            exp_last_q[$];
  int            need_cnt = 0;
  int            stray_cnt = 0;
  int            ready_mode = 0;
  int            done_cnt = 0;
  int            perm_cnt = 0;
  int            xfer_cnt = 0;
  bit            busy_seen = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Consumer ready pattern
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[3 - ph]; ph = (ph + 1) % 4; end
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // State provider: supplies the next queued block after a short random wait
  initial begin
    state_valid = 1'b0;
    state_in = '0;
    forever begin
      @(posedge clk); #1;
      state_valid = 1'b0;
      if (need_cnt > 0 && blk_q.size() > 0) begin
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
        state_in = blk_q.pop_front();
        state_valid = 1'b1;
        need_cnt--;
      end else if (stray_cnt > 0) begin
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++) state_in[x][y] = {$urandom, $urandom};
        state_valid = 1'b1;
        stray_cnt--;
      end
    end
  end

  // Monitor: pops expected words on every transfer, checks stall stability
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_last, out_data[61:0]}, {1'b1, prev_last, prev_data[61:0]});
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_word", 64'(out_valid), 64'd0);
        end else begin
          check("word_data", out_data, exp_data_q.pop_front());
          check("word_last", 64'(out_last), 64'(exp_last_q.pop_front()));
        end
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (perm_req) begin perm_cnt++; need_cnt++; end
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
    end
  end

  // Builds blocks as lane lists, packs them into A[x][y], queues expected words, runs one squeeze
  task automatic run_txn(input int unsigned len, input bit pattern, input bit dup_start);
    int unsigned nblk;
    int d0, p0;
    bit got;
    nblk = (len + RL - 1) / RL;
    for (int unsigned b = 0; b < nblk; b++) begin
      logic [63:0]   lanes [25];
      keccak_state_t s;
      for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
      if (pattern && b < 2)
        for (int i = 0; i < int'(RL); i++)
          lanes[i] = ((b == 0) ? 64'hA5A5_0000_0000_0000 : 64'h5A5A_0000_0000_0000) | 64'(i);
      for (int i = 0; i < 25; i++) s[i % 5][i / 5] = lanes[i];
      blk_q.push_back(s);
      for (int unsigned k = b * RL; k < len && k < (b + 1) * RL; k++) begin
        exp_data_q.push_back(lanes[k - b * RL]);
        exp_last_q.push_back(k == len - 1);
      end
    end
    d0 = done_cnt;
    p0 = perm_cnt;
    if (nblk > 0) need_cnt++;
    start = 1'b1; out_len = 16'(len);
    @(posedge clk); #1;
    start = 1'b0; out_len = '0;
    if (dup_start) begin
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b1; out_len = 16'd7;
      @(posedge clk); #1;
      start = 1'b0; out_len = '0;
    end
    got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(posedge clk);
      if (done_cnt != d0) got = 1;
    end
    check("done_seen", 64'(got), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("perm_count", 64'(perm_cnt - p0), (nblk > 0) ? 64'(nblk - 1) : 64'd0);
    check("words_left", 64'(exp_data_q.size()), 64'd0);
    exp_data_q.delete(); exp_last_q.delete(); blk_q.delete(); need_cnt = 0;
  endtask

  initial begin
    int d0;
    bit got;
    rst = 1'b1; start = 1'b0; out_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_perm_req", 64'(perm_req), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;

    ready_mode = 0;
    run_txn(3, 1, 0);
    run_txn(17, 1, 0);
    run_txn(20, 1, 0);
    ready_mode = 1;
    run_txn(9, 1, 0);
    run_txn(20, 1, 0);

    // Zero-length request: done only, never busy
    ready_mode = 0;
    busy_seen = 0;
    run_txn(0, 0, 0);
    check("len0_busy", 64'(busy_seen), 64'd0);

    // Start while busy must not extend or restart the squeeze
    ready_mode = 2;
    run_txn(40, 0, 1);

    // Stray state_valid in IDLE
    stray_cnt = 2;
    repeat (6) @(posedge clk);
    #1;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_valid", 64'(out_valid), 64'd0);

    // Reset in EMIT after the second word
    ready_mode = 0;
    begin
      logic [63:0] lanes [25];
      keccak_state_t s;
      int x0;
      for (int i = 0; i < 25; i++) lanes[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      for (int i = 0; i < 25; i++) s[i % 5][i / 5] = lanes[i];
      blk_q.push_back(s);
      for (int i = 0; i < 5; i++) begin
        exp_data_q.push_back(lanes[i]);
        exp_last_q.push_back(i == 4);
      end
      x0 = xfer_cnt;
      d0 = done_cnt;
      need_cnt++;
      start = 1'b1; out_len = 16'd5;
      @(posedge clk); #1;
      start = 1'b0; out_len = '0;
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(posedge clk);
        if (xfer_cnt - x0 >= 2) got = 1;
      end
      check("two_words_seen", 64'(got), 64'd1);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_data_q.delete(); exp_last_q.delete(); blk_q.delete(); need_cnt = 0;
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_data", out_data, 64'd0);
      check("midrst_last", 64'(out_last), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_perm", 64'(perm_req), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    end
    run_txn(1, 1, 0);

    // Randomized squeezes
    for (int t = 0; t < 30; t++) begin
      ready_mode = int'($urandom_range(2, 0));
      run_txn($urandom_range(60, 1), 0, 1'($urandom_range(1, 0)) && 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
